// File: rtl/decode_issue_ctrl.sv
// Decode/execute issue interlock: register scoreboard, hazard stall and exception sequencing.
// Optional DECODE_BYPASS_EN lets a same-cycle writeback clear the hazard seen by decode.
module decode_issue_ctrl #(
   parameter int NUM_REGS      = 32,
   parameter int ADDR_W        = 5,
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              dec_valid_in,
   input  logic [ADDR_W-1:0] reg_a_addr_in,
   input  logic [ADDR_W-1:0] reg_b_addr_in,
   input  logic              reg_a_used_in,
   input  logic              reg_b_used_in,
   input  logic [ADDR_W-1:0] reg_d_addr_in,
   input  logic              reg_d_we_in,
   input  logic              long_lat_in,
   input  logic              flag_ill_inst_in,
   input  logic              flag_syscall_in,
   input  logic              issue_ready_in,
   input  logic              wb_valid_in,
   input  logic [ADDR_W-1:0] wb_addr_in,
   input  logic              exc_ack_in,
   output logic              issue_valid_out,
   output logic              stall_out,
   output logic              flush_out,
   output logic              exc_valid_out,
   output logic [1:0]        exc_cause_out,
   output logic              busy_out
);

   // state    | meaning
   // ST_RUN   | normal issue, hazards interlocked against the scoreboard
   // ST_DRAIN | exception seen, waiting for outstanding writebacks (bounded)
   // ST_EXC   | exception presented, waiting for exc_ack_in
   // ST_FLUSH | one-cycle pipeline flush, then back to ST_RUN
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_EXC, ST_FLUSH} state_t;

   state_t              state_q;
   logic [NUM_REGS-1:0] sb_q, sb_d, sb_set, sb_clr, sb_eff;
   logic [7:0]          cnt_q;
   logic [1:0]          cause_q;
   logic                exc_valid_q, flush_q, busy_q;
   logic                hazard, exc_flag, issue;

   always_comb begin
      sb_clr = '0;
      if (wb_valid_in) sb_clr[wb_addr_in] = 1'b1;
   end

`ifdef DECODE_BYPASS_EN
   assign sb_eff = sb_q & ~sb_clr;
`else
   assign sb_eff = sb_q;
`endif

   assign hazard   = (reg_a_used_in & sb_eff[reg_a_addr_in])
                   | (reg_b_used_in & sb_eff[reg_b_addr_in])
                   | (reg_d_we_in   & sb_eff[reg_d_addr_in]);
   assign exc_flag = flag_ill_inst_in | flag_syscall_in;
   assign issue    = (state_q == ST_RUN) & dec_valid_in & ~exc_flag & ~hazard & issue_ready_in;

   // Set is OR-ed in after the clear so a same-cycle set of a retiring register wins.
   always_comb begin
      sb_set = '0;
      if (issue && reg_d_we_in && long_lat_in && (reg_d_addr_in != '0))
         sb_set[reg_d_addr_in] = 1'b1;
      sb_d    = (sb_q & ~sb_clr) | sb_set;
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_q     <= ST_RUN;
         sb_q        <= '0;
         cnt_q       <= '0;
         cause_q     <= 2'b00;
         exc_valid_q <= 1'b0;
         flush_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sb_q   <= sb_d;
         busy_q <= |sb_d;
         case (state_q)
            ST_RUN: begin
               if (dec_valid_in && exc_flag) begin
                  cause_q <= flag_ill_inst_in ? 2'b01 : 2'b10;
                  cnt_q   <= '0;
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (sb_q == '0) begin
                  exc_valid_q <= 1'b1;
                  state_q     <= ST_EXC;
               end else if (cnt_q == 8'(DRAIN_TIMEOUT - 1)) begin
                  cause_q     <= 2'b11;
                  exc_valid_q <= 1'b1;
                  state_q     <= ST_EXC;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_EXC: begin
               if (exc_ack_in) begin
                  exc_valid_q <= 1'b0;
                  flush_q     <= 1'b1;
                  state_q     <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               flush_q <= 1'b0;
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   assign issue_valid_out = issue;
   assign stall_out       = (state_q != ST_RUN) | (dec_valid_in & ~issue);
   assign flush_out       = flush_q;
   assign exc_valid_out   = exc_valid_q;
   assign exc_cause_out   = cause_q;
   assign busy_out        = busy_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed scenarios plus random traffic against a
// behavioural model of pending registers and the exception sequence.
module tb_decode_issue_ctrl;

`ifdef DECODE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic       clk_in = 1'b0;
   logic       reset_in;
   logic       dec_valid_in;
   logic [4:0] reg_a_addr_in, reg_b_addr_in, reg_d_addr_in, wb_addr_in;
   logic       reg_a_used_in, reg_b_used_in, reg_d_we_in, long_lat_in;
   logic       flag_ill_inst_in, flag_syscall_in, issue_ready_in, wb_valid_in, exc_ack_in;
   logic       issue_valid_out, stall_out, flush_out, exc_valid_out, busy_out;
   logic [1:0] exc_cause_out;

   decode_issue_ctrl dut (
      .clk_in(clk_in), .reset_in(reset_in), .dec_valid_in(dec_valid_in),
      .reg_a_addr_in(reg_a_addr_in), .reg_b_addr_in(reg_b_addr_in),
      .reg_a_used_in(reg_a_used_in), .reg_b_used_in(reg_b_used_in),
      .reg_d_addr_in(reg_d_addr_in), .reg_d_we_in(reg_d_we_in), .long_lat_in(long_lat_in),
      .flag_ill_inst_in(flag_ill_inst_in), .flag_syscall_in(flag_syscall_in),
      .issue_ready_in(issue_ready_in), .wb_valid_in(wb_valid_in), .wb_addr_in(wb_addr_in),
      .exc_ack_in(exc_ack_in), .issue_valid_out(issue_valid_out), .stall_out(stall_out),
      .flush_out(flush_out), .exc_valid_out(exc_valid_out), .exc_cause_out(exc_cause_out),
      .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit       rst_n, dv, au, bu, we, ll, ill, sys, rdy, wbv, ack;
      bit [4:0] a, b, d, wba;
   } stim_t;

   typedef struct {
      bit       iss, stl, fl, ev, bz;
      bit [1:0] cs;
      int       cyc;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cycle      = 0;

   // Model: set of owed registers plus a position in the exception sequence.
   bit       owed[32];
   string    phase;       // "run", "drain", "exc", "flush"
   int       drain_waited;
   bit [1:0] cause;

   function automatic bit reg_busy(input stim_t s, input bit [4:0] r);
      if (r == 0 || !owed[r]) return 1'b0;
      if (BYPASS && s.wbv && s.wba == r) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit any_owed();
      foreach (owed[i]) if (owed[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_reset();
      foreach (owed[i]) owed[i] = 1'b0;
      phase        = "run";
      drain_waited = 0;
      cause        = 2'b00;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      s.rst_n = 1'b1;
      s.rdy   = 1'b1;
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit   haz, was_owed;
      reset_in = s.rst_n;         dec_valid_in = s.dv;
      reg_a_addr_in = s.a;        reg_b_addr_in = s.b;      reg_d_addr_in = s.d;
      reg_a_used_in = s.au;       reg_b_used_in = s.bu;     reg_d_we_in = s.we;
      long_lat_in = s.ll;         flag_ill_inst_in = s.ill; flag_syscall_in = s.sys;
      issue_ready_in = s.rdy;     wb_valid_in = s.wbv;      wb_addr_in = s.wba;
      exc_ack_in = s.ack;

      haz   = (s.au && reg_busy(s, s.a)) || (s.bu && reg_busy(s, s.b)) || (s.we && reg_busy(s, s.d));
      e.iss = (phase == "run") && s.dv && !s.ill && !s.sys && !haz && s.rdy;
      e.stl = (phase != "run") || (s.dv && !e.iss);
      e.fl  = (phase == "flush");
      e.ev  = (phase == "exc");
      e.cs  = cause;
      e.bz  = any_owed();
      e.cyc = cycle;
      exp_q.push_back(e);

      was_owed = any_owed();
      if (!s.rst_n) begin
         model_reset();
      end else begin
         if (s.wbv) owed[s.wba] = 1'b0;
         if (e.iss && s.we && s.ll && s.d != 0) owed[s.d] = 1'b1;
         if (phase == "run") begin
            if (s.dv && (s.ill || s.sys)) begin
               cause        = s.ill ? 2'b01 : 2'b10;
               drain_waited = 0;
               phase        = "drain";
            end
         end else if (phase == "drain") begin
            drain_waited++;
            if (!was_owed) phase = "exc";
            else if (drain_waited == 255) begin
               cause = 2'b11;
               phase = "exc";
            end
         end else if (phase == "exc") begin
            if (s.ack) phase = "flush";
         end else begin
            phase = "run";
         end
      end
      @(posedge clk_in);
      #1;
      cycle++;
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (issue_valid_out !== e.iss || stall_out !== e.stl || flush_out !== e.fl ||
             exc_valid_out !== e.ev || exc_cause_out !== e.cs || busy_out !== e.bz) begin
            mismatched++;
            $display("FAIL outputs cyc %0d: got iss=%b stall=%b flush=%b exc=%b cause=%b busy=%b, want iss=%b stall=%b flush=%b exc=%b cause=%b busy=%b",
                     e.cyc, issue_valid_out, stall_out, flush_out, exc_valid_out, exc_cause_out, busy_out,
                     e.iss, e.stl, e.fl, e.ev, e.cs, e.bz);
         end
      end
   end

   initial begin
      stim_t s;
      s = idle();
      s.rst_n = 1'b0;
      reset_in = 1'b0; dec_valid_in = 1'b0; reg_a_addr_in = '0; reg_b_addr_in = '0;
      reg_d_addr_in = '0; wb_addr_in = '0; reg_a_used_in = 1'b0; reg_b_used_in = 1'b0;
      reg_d_we_in = 1'b0; long_lat_in = 1'b0; flag_ill_inst_in = 1'b0; flag_syscall_in = 1'b0;
      issue_ready_in = 1'b0; wb_valid_in = 1'b0; exc_ack_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      compared++;
      if (flush_out !== 1'b0 || exc_valid_out !== 1'b0 || exc_cause_out !== 2'b00 || busy_out !== 1'b0) begin
         mismatched++;
         $display("FAIL reset state: flush=%b exc=%b cause=%b busy=%b",
                  flush_out, exc_valid_out, exc_cause_out, busy_out);
      end
      model_reset();

      // Load to r5, dependent read stalls until writeback.
      s = idle(); s.dv = 1; s.we = 1; s.ll = 1; s.d = 5; step(s);
      s = idle(); s.dv = 1; s.au = 1; s.a = 5;
      repeat (3) step(s);
      s.wbv = 1; s.wba = 5; step(s);
      s.wbv = 0; step(s);
      step(idle());

      // Long-latency write to r0 is never tracked.
      s = idle(); s.dv = 1; s.we = 1; s.ll = 1; s.d = 0; step(s);
      s = idle(); s.dv = 1; s.au = 1; s.a = 0; s.bu = 1; s.b = 0; step(s);

      // Illegal and syscall together with empty scoreboard.
      s = idle(); s.dv = 1; s.ill = 1; s.sys = 1; step(s);
      s = idle(); s.dv = 1; s.ill = 1; s.sys = 1; s.rdy = 0; s.dv = 0;
      repeat (3) step(idle());
      s = idle(); s.ack = 1; step(s);
      repeat (3) step(idle());

      // Syscall while r3 is owed: drain until r3 retires.
      s = idle(); s.dv = 1; s.we = 1; s.ll = 1; s.d = 3; step(s);
      s = idle(); s.dv = 1; s.sys = 1;
      repeat (6) step(s);
      s.wbv = 1; s.wba = 3; step(s);
      s.wbv = 0;
      repeat (3) step(s);
      s.ack = 1; step(s);
      repeat (3) step(idle());

      // No writeback during drain: timeout cause.
      s = idle(); s.dv = 1; s.we = 1; s.ll = 1; s.d = 7; step(s);
      s = idle(); s.dv = 1; s.ill = 1; step(s);
      repeat (260) step(idle());
      compared++;
      if (exc_valid_out !== 1'b1 || exc_cause_out !== 2'b11) begin
         mismatched++;
         $display("FAIL drain timeout: exc=%b cause=%b, want exc=1 cause=11",
                  exc_valid_out, exc_cause_out);
      end
      s = idle(); s.ack = 1; step(s);
      repeat (2) step(idle());
      s = idle(); s.wbv = 1; s.wba = 7; step(s);
      step(idle());

      // Reset while an exception is pending, with a register owed.
      s = idle(); s.dv = 1; s.we = 1; s.ll = 1; s.d = 9; step(s);
      s = idle(); s.dv = 1; s.sys = 1; step(s);
      s = idle(); s.wbv = 1; s.wba = 9; step(s);
      repeat (3) step(idle());
      s = idle(); s.dv = 1; s.we = 1; s.ll = 1; s.d = 4; s.rst_n = 0; step(s);
      s = idle(); s.dv = 1; s.au = 1; s.a = 4; step(s);
      step(idle());

      // Random traffic over a small register window to provoke hazards.
      for (int i = 0; i < 3000; i++) begin
         s       = idle();
         s.rst_n = ($urandom_range(0, 399) != 0);
         s.dv    = ($urandom_range(0, 9) < 7);
         s.a     = 5'($urandom_range(0, 7));
         s.b     = 5'($urandom_range(0, 7));
         s.d     = 5'($urandom_range(0, 7));
         s.au    = $urandom_range(0, 1);
         s.bu    = $urandom_range(0, 1);
         s.we    = $urandom_range(0, 1);
         s.ll    = ($urandom_range(0, 9) < 4);
         s.ill   = ($urandom_range(0, 99) < 2);
         s.sys   = ($urandom_range(0, 99) < 2);
         s.rdy   = ($urandom_range(0, 9) < 8);
         s.wbv   = ($urandom_range(0, 9) < 3);
         s.wba   = 5'($urandom_range(0, 7));
         s.ack   = ($urandom_range(0, 3) == 0);
         step(s);
      end

      @(negedge clk_in);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Issue/interlock controller between the 32-bit decode stage and execute. Keeps a register scoreboard of destinations owed by long-latency operations (loads, multi-cycle ALU/FPU), stalls decode on RAW/WAW hazards, and sequences illegal-instruction and syscall exceptions: drain outstanding writes, raise the exception, wait for acknowledge, flush.

## Interface
- NUM_REGS, 32, architectural registers; r0 is never tracked
- ADDR_W, 5, register address width; log2(NUM_REGS)
- DRAIN_TIMEOUT, 255, maximum DRAIN cycles before a timeout exception; 8-bit counter
- clk_in  in  1  single clock, rising edge
- reset_in  in  1  synchronous, active-low reset
- dec_valid_in  in  1  decode holds a valid decoded instruction
- reg_a_addr_in / reg_b_addr_in  in  ADDR_W  source operand addresses
- reg_a_used_in / reg_b_used_in  in  1  operand actually read
- reg_d_addr_in  in  ADDR_W  destination address
- reg_d_we_in  in  1  instruction writes reg_d
- long_lat_in  in  1  reg_d is written later via the writeback port
- flag_ill_inst_in / flag_syscall_in  in  1  exception flags from decode
- issue_ready_in  in  1  execute accepts this cycle
- wb_valid_in  in  1  long-latency writeback retiring
- wb_addr_in  in  ADDR_W  retiring register
- exc_ack_in  in  1  exception unit accepted the exception
- issue_valid_out  out  1  instruction issued this cycle (combinational)
- stall_out  out  1  decode must hold (combinational)
- flush_out  out  1  one-cycle pipeline flush (registered)
- exc_valid_out  out  1  exception pending (registered)
- exc_cause_out  out  2  01 illegal, 10 syscall, 11 drain timeout
- busy_out  out  1  scoreboard non-empty (registered)

## Operation
- Scoreboard: NUM_REGS bits, bit 0 hard-wired 0.
- States: RUN, DRAIN, EXC, FLUSH.
- hazard = (a_used & sb[a]) | (b_used & sb[b]) | (d_we & sb[d]); sb is the effective scoreboard (see Configuration).
- RUN: issue_valid_out = dec_valid & ~exc_flag & ~hazard & issue_ready_in; stall_out = dec_valid & ~issue_valid_out.
- On issue with d_we & long_lat & d≠0: set sb[d]. On wb_valid: clear sb[wb_addr]. Same register set and cleared in one cycle: set wins.
- RUN with dec_valid & (ill | syscall): no issue, latch cause (ill has priority over syscall), go to DRAIN; stall_out held high through DRAIN, EXC, FLUSH.
- DRAIN: wait for sb == 0, then go to EXC. Counter increments each DRAIN cycle; reaching DRAIN_TIMEOUT forces cause 11 and goes to EXC.
- EXC: exc_valid_out=1, exc_cause_out stable until exc_ack_in; then go to FLUSH.
- FLUSH: flush_out=1 for exactly one cycle; sb is NOT cleared (writebacks still retire); then back to RUN.
- Writebacks are honoured in every state.
- Reset mid-sequence: immediate return to RUN; scoreboard, counter and cause are cleared.

## Timing
- Reset values: state RUN, sb 0, counter 0, exc_valid_out 0, exc_cause_out 00, flush_out 0, busy_out 0.
- issue_valid_out / stall_out: same-cycle functions of inputs and registered state.
- Scoreboard set/clear takes effect at the next rising edge.
- Exception latency with empty sb: flag in cycle N → exc_valid_out in N+2 (DRAIN sees sb==0 in N+1).
- flush_out follows the exc_ack_in cycle by one cycle.
- busy_out reflects sb after the edge.

## Configuration
- DECODE_BYPASS_EN defined: hazard is computed on sb with the same-cycle wb_valid clear applied, so a dependent instruction issues in the writeback cycle.
- DECODE_BYPASS_EN undefined: hazard uses the registered sb only, adding one stall cycle after writeback. DRAIN empty-check uses the registered sb in both builds.

## Test plan
- Load to r5 issued (long_lat), next instruction reads r5 → stall until wb_valid r5; with bypass, issue in the wb cycle; without, issue one cycle later.
- Long-latency write to r0 → no sb bit set, busy_out stays 0, no stall on a later r0 read.
- flag_ill_inst_in and flag_syscall_in both set, sb empty → exc_valid_out at N+2 with cause 01; exc_ack_in → flush_out one cycle, then RUN.
- Syscall with r3 pending → DRAIN holds until wb r3, then EXC cause 10; decode stalled throughout.
- No writeback during DRAIN → after 255 cycles, exc_cause_out=11.
- reset_in low during EXC → next cycle: exc_valid_out 0, busy_out 0, state RUN, issue resumes.
